txt_glyph_arbiter: RTL and testbench
====================================

# txt_glyph_arbiter

Round-robin arbiter sharing the single glyph ROM (`memory_txt`, 1-cycle registered read) between up to NREQ text-overlay renderers: score, game-over banner, menu, combo counter. Each cycle it grants at most one requester, registers that requester's glyph index and cell coordinates onto the ROM port, and returns the ROM pixel two cycles later with a one-hot tag. It sits between the per-screen `*_pixel` generators and the ROM, ahead of the VGA pixel mux.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `ADDR_W`, 6: glyph index width
- `PT_W`, 3: cell coordinate width (h/v point within glyph)
- `PIX_W`, 12: RGB444 pixel width
- `clk` in 1: pixel-domain clock
- `rst_n` in 1: asynchronous, active-low reset
- `req` in NREQ: per-requester read request, level
- `req_addr` in NREQ*ADDR_W: glyph index, requester i at bits [i*ADDR_W +: ADDR_W]
- `req_h` in NREQ*PT_W: horizontal cell coordinate, packed as above
- `req_v` in NREQ*PT_W: vertical cell coordinate, packed as above
- `req_lock` in NREQ: hold grant for a burst (only with `TXT_ARB_LOCK_EN`)
- `gnt` out NREQ: one-hot grant, combinational from `req` and state
- `rom_addr` out ADDR_W: registered ROM glyph index
- `rom_h` out PT_W: registered ROM h point
- `rom_v` out PT_W: registered ROM v point
- `rom_pixel` in PIX_W: ROM data, valid 1 cycle after `rom_*` update
- `rsp_valid` out NREQ: one-hot, 1-cycle pulse marking `rsp_pixel` owner
- `rsp_pixel` out PIX_W: returned pixel, registered

## Operation
- Priority pointer `ptr` (log2 NREQ bits) names the highest-priority requester. Winner is the first set `req` bit scanning ptr, ptr+1, … modulo NREQ.
- On a grant to i, `ptr` becomes (i+1) mod NREQ at the next edge. Wrap from NREQ-1 goes to 0.
- No request: `gnt`=0, `ptr` unchanged, `rom_*` hold their last value, and no tag enters the pipeline.
- Stage 1 (edge after grant): `rom_addr/h/v` take the winner's fields, and `tag1` takes `gnt`.
- Stage 2: `tag2` takes `tag1`, and the ROM produces `rom_pixel`.
- Stage 3: `rsp_pixel` takes `rom_pixel`, and `rsp_valid` takes `tag2`. When `tag2`=0, `rsp_pixel` holds its value and `rsp_valid`=0.
- A requester may hold `req` every cycle. Under contention each active requester is granted at least once every NREQ cycles.
- Requests are not queued. The requester re-presents fields on every cycle until `gnt[i]` is seen. Fields are sampled only in the granted cycle.
- `rsp_valid` is at most one-hot. The bench must check this every cycle.

## Timing
- Reset values: `gnt`=0 (pipeline idle, no req considered until deassert), `ptr`=0, `rom_addr`=0, `rom_h`=0, `rom_v`=0, `tag1`=`tag2`=0, `rsp_valid`=0, `rsp_pixel`=0, lock state IDLE.
- Latency: grant in cycle N gives `rsp_valid` in cycle N+3, i.e. after three rising edges.
- Throughput: one grant per cycle, fully pipelined.
- Reset mid-operation: all in-flight tags are discarded immediately (async). No `rsp_valid` follows the reset release until a new grant.
- `req` rising and granted in the same cycle is allowed. `gnt` is combinational, so `req` must be stable before the edge.

## Configuration
- `TXT_ARB_LOCK_EN` defined: two-state FSM with states IDLE and LOCKED(owner).
  - IDLE to LOCKED: granted requester i has `req_lock[i]`=1.
  - In LOCKED, only the owner is granted, and only while `req[owner]`=1. Other requests wait.
  - LOCKED to IDLE: the first cycle with `req_lock[owner]`=0 or `req[owner]`=0. Arbitration resumes that same cycle with `ptr` = owner+1.
  - Burst cap is 16 consecutive grants (4-bit counter). On the 16th grant the FSM forces IDLE, and the owner must drop `req_lock` for one cycle before it can lock again.
- `TXT_ARB_LOCK_EN` not defined: `req_lock` is ignored, there is no FSM, and the arbiter is pure round-robin.

## Test plan
- Reset, then `req`=4'b0000 for 10 cycles -> `gnt`=0, `rsp_valid`=0, `rom_addr`=0 throughout.
- `req`=4'b1111 held, each requester's `req_addr`=16,10,22,14 -> `gnt` sequence 0001,0010,0100,1000,0001…; `rsp_valid` repeats the same sequence 3 cycles later; `rsp_pixel` matches the ROM model for each addr.
- `req`=4'b0100 alone, addr=31, h=2, v=4 -> `gnt`=0100 every cycle; `rom_addr`=31 after 1 edge; `rsp_valid`=0100 from cycle 3 onward.
- `ptr`=3 with `req`=4'b1001 -> grant bit 3, then bit 0 (wrap), then bit 3.
- Grant issued, `rst_n` pulsed low for 1 cycle before the response -> `rsp_valid` stays 0, `rsp_pixel`=0, `ptr`=0.
- With `TXT_ARB_LOCK_EN`: req1 locks while `req`=4'b1111 -> 16 consecutive `gnt`=0010, then `gnt`=0100 on the next cycle.

Source files
------------

// File: rtl/txt_glyph_arbiter.sv
// Round-robin arbiter sharing the registered glyph ROM between text-overlay renderers.
// Optional burst locking is compiled in with `define TXT_ARB_LOCK_EN.
module txt_glyph_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 6,
    parameter int PT_W   = 3,
    parameter int PIX_W  = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*PT_W-1:0]   req_h,
    input  logic [NREQ*PT_W-1:0]   req_v,
    input  logic [NREQ-1:0]        req_lock,
    output logic [NREQ-1:0]        gnt,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic [PT_W-1:0]        rom_h,
    output logic [PT_W-1:0]        rom_v,
    input  logic [PIX_W-1:0]       rom_pixel,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [PIX_W-1:0]       rsp_pixel
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] ptr_next;
    logic             found;
    logic [NREQ-1:0]  req_eff;
    logic [NREQ-1:0]  gnt_raw;
    logic [NREQ-1:0]  tag1;
    logic [NREQ-1:0]  tag2;

    // First set request scanning ptr, ptr+1, ... modulo NREQ.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        gnt_raw = '0;
        win     = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NREQ)) sum = sum - (PTR_W+1)'(NREQ);
            idx = sum[PTR_W-1:0];
            if (!found && req_eff[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found) gnt_raw[win] = 1'b1;
    end

    assign ptr_next = (win == PTR_W'(NREQ - 1)) ? '0 : win + 1'b1;
    // Requests are not considered while reset is asserted.
    assign gnt      = rst_n ? gnt_raw : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            rom_addr  <= '0;
            rom_h     <= '0;
            rom_v     <= '0;
            tag1      <= '0;
            tag2      <= '0;
            rsp_valid <= '0;
            rsp_pixel <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
            tag1      <= gnt_raw;
            tag2      <= tag1;
            rsp_valid <= tag2;
            if (|tag2) rsp_pixel <= rom_pixel;
            if (found) begin
                ptr      <= ptr_next;
                rom_addr <= req_addr[win*ADDR_W +: ADDR_W];
                rom_h    <= req_h[win*PT_W +: PT_W];
                rom_v    <= req_v[win*PT_W +: PT_W];
            end
        end
    end

`ifdef TXT_ARB_LOCK_EN
    typedef enum logic {IDLE, LOCKED} lock_state_t;

    lock_state_t      state, state_next;
    logic [PTR_W-1:0] owner, owner_next;
    logic [3:0]       burst, burst_next;
    logic [NREQ-1:0]  block, block_next;
    logic             hold;

    // While locked, the owner is the only candidate for as long as it keeps req and req_lock high.
    assign hold = (state == LOCKED) && req[owner] && req_lock[owner];

    always_comb begin
        req_eff = req;
        if (hold) begin
            req_eff        = '0;
            req_eff[owner] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        burst_next = burst;
        // A capped owner stays blocked until it drops req_lock for a cycle.
        block_next = block & req_lock;
        if (hold) begin
            if (burst == 4'd15) begin
                state_next        = IDLE;
                block_next[owner] = 1'b1;
            end else begin
                burst_next = burst + 4'd1;
            end
        end else begin
            state_next = IDLE;
            if (found && req_lock[win] && !block[win]) begin
                state_next = LOCKED;
                owner_next = win;
                burst_next = 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            burst <= '0;
            block <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            burst <= burst_next;
            block <= block_next;
        end
    end
`else
    logic unused_lock;

    assign req_eff     = req;
    assign unused_lock = ^req_lock;
`endif

endmodule

// File: tb/tb_txt_glyph_arbiter.sv
// Directed bench for txt_glyph_arbiter: vector table for arbitration order and latency,
// hand sequences for single requester, wrap, async reset and (optionally) burst locking.
module tb_txt_glyph_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 6;
    localparam int PT_W   = 3;
    localparam int PIX_W  = 12;

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*PT_W-1:0]   req_h;
    logic [NREQ*PT_W-1:0]   req_v;
    logic [NREQ-1:0]        req_lock;
    logic [NREQ-1:0]        gnt;
    logic [ADDR_W-1:0]      rom_addr;
    logic [PT_W-1:0]        rom_h;
    logic [PT_W-1:0]        rom_v;
    logic [PIX_W-1:0]       rom_pixel;
    logic [NREQ-1:0]        rsp_valid;
    logic [PIX_W-1:0]       rsp_pixel;

    logic [ADDR_W-1:0] f_addr [NREQ];
    logic [PT_W-1:0]   f_h    [NREQ];
    logic [PT_W-1:0]   f_v    [NREQ];
    logic [PIX_W-1:0]  exp_pix;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] gnt;
        logic [NREQ-1:0] rv;
    } vec_t;

    vec_t tbl [18];

    txt_glyph_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .PT_W(PT_W), .PIX_W(PIX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
        .req_h(req_h), .req_v(req_v), .req_lock(req_lock), .gnt(gnt),
        .rom_addr(rom_addr), .rom_h(rom_h), .rom_v(rom_v),
        .rom_pixel(rom_pixel), .rsp_valid(rsp_valid), .rsp_pixel(rsp_pixel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Glyph ROM stand-in: one-cycle registered read, pixel encodes its own address.
    always @(posedge clk) rom_pixel <= {rom_addr, rom_h, rom_v};

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = f_addr[i];
            req_h[i*PT_W +: PT_W]        = f_h[i];
            req_v[i*PT_W +: PT_W]        = f_v[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [PIX_W-1:0] pix_of(input logic [NREQ-1:0] oh);
        logic [PIX_W-1:0] p;
        p = '0;
        for (int j = 0; j < NREQ; j++)
            if (oh[j]) p = {f_addr[j], f_h[j], f_v[j]};
        return p;
    endfunction

    always @(negedge clk) check("rsp_valid onehot", 32'($onehot0(rsp_valid)), 32'd1);

    // One cycle: drive at posedge+1, compare at negedge, return at next posedge+1.
    task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                       input logic [NREQ-1:0] eg, input logic [NREQ-1:0] erv, input string nm);
        req      = r;
        req_lock = l;
        if (erv != '0) exp_pix = pix_of(erv);
        @(negedge clk);
        check({nm, " gnt"}, 32'(gnt), 32'(eg));
        check({nm, " rsp_valid"}, 32'(rsp_valid), 32'(erv));
        check({nm, " rsp_pixel"}, 32'(rsp_pixel), 32'(exp_pix));
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 4'b0001, 4'b0000};
        tbl[1]  = '{4'b1111, 4'b0010, 4'b0000};
        tbl[2]  = '{4'b1111, 4'b0100, 4'b0000};
        tbl[3]  = '{4'b1111, 4'b1000, 4'b0001};
        tbl[4]  = '{4'b1111, 4'b0001, 4'b0010};
        tbl[5]  = '{4'b1111, 4'b0010, 4'b0100};
        tbl[6]  = '{4'b0000, 4'b0000, 4'b1000};
        tbl[7]  = '{4'b1001, 4'b1000, 4'b0001};
        tbl[8]  = '{4'b1001, 4'b0001, 4'b0010};
        tbl[9]  = '{4'b1001, 4'b1000, 4'b0000};
        tbl[10] = '{4'b0110, 4'b0010, 4'b1000};
        tbl[11] = '{4'b0110, 4'b0100, 4'b0001};
        tbl[12] = '{4'b0100, 4'b0100, 4'b1000};
        tbl[13] = '{4'b0100, 4'b0100, 4'b0010};
        tbl[14] = '{4'b0000, 4'b0000, 4'b0100};
        tbl[15] = '{4'b0000, 4'b0000, 4'b0100};
        tbl[16] = '{4'b0000, 4'b0000, 4'b0100};
        tbl[17] = '{4'b0000, 4'b0000, 4'b0000};

        f_addr[0] = 6'd16; f_addr[1] = 6'd10; f_addr[2] = 6'd22; f_addr[3] = 6'd14;
        for (int i = 0; i < NREQ; i++) begin
            f_h[i] = PT_W'(i);
            f_v[i] = PT_W'(7 - i);
        end
        exp_pix  = '0;
        req      = '0;
        req_lock = '0;
        rst_n    = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset gnt", 32'(gnt), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_pixel", 32'(rsp_pixel), 32'd0);
        check("reset rom_addr", 32'(rom_addr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle: nothing granted, ROM port untouched
        for (int k = 0; k < 10; k++) begin
            cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, "idle");
            check("idle rom_addr", 32'(rom_addr), 32'd0);
        end

        // Round-robin order, 3-cycle latency, wrap from 3 to 0
        for (int i = 0; i < 18; i++)
            cyc(tbl[i].req, 4'b0000, tbl[i].gnt, tbl[i].rv, $sformatf("vec%0d", i));

        // Single requester 2 streaming, new fields
        f_addr[2] = 6'd31;
        f_h[2]    = 3'd2;
        f_v[2]    = 3'd4;
        for (int k = 0; k < 6; k++) begin
            cyc(4'b0100, 4'b0000, 4'b0100, (k >= 3) ? 4'b0100 : 4'b0000, $sformatf("solo%0d", k));
            check("solo rom_addr", 32'(rom_addr), 32'd31);
            check("solo rom_h", 32'(rom_h), 32'd2);
            check("solo rom_v", 32'(rom_v), 32'd4);
        end

        // Grant then async reset before the response returns
        cyc(4'b0001, 4'b0000, 4'b0001, 4'b0100, "pre_rst");
        rst_n   = 1'b0;
        req     = 4'b1111;
        exp_pix = '0;
        @(negedge clk);
        check("in_rst gnt", 32'(gnt), 32'd0);
        check("in_rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("in_rst rsp_pixel", 32'(rsp_pixel), 32'd0);
        check("in_rst rom_addr", 32'(rom_addr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++)
            cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, $sformatf("post_rst%0d", k));
        cyc(4'b1111, 4'b0000, 4'b0001, 4'b0000, "post_rst ptr0");
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, "drain_a");
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, "drain_b");
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0001, "drain_c");

`ifdef TXT_ARB_LOCK_EN
        // Requester 1 locks: 16 consecutive grants, then the cap forces rotation
        for (int k = 0; k < 16; k++)
            cyc(4'b1111, 4'b0010, 4'b0010, (k >= 3) ? 4'b0010 : 4'b0000, $sformatf("lock%0d", k));
        cyc(4'b1111, 4'b0010, 4'b0100, 4'b0010, "cap_exit");
        cyc(4'b1111, 4'b0010, 4'b1000, 4'b0010, "cap_rr3");
        cyc(4'b1111, 4'b0010, 4'b0001, 4'b0010, "cap_rr0");
        cyc(4'b1111, 4'b0010, 4'b0010, 4'b0100, "blocked_gnt");
        cyc(4'b1111, 4'b0010, 4'b0100, 4'b1000, "no_relock");
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0001, "lk_drain0");
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0010, "lk_drain1");
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0100, "lk_drain2");
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, "lk_drain3");
`else
        // req_lock has no effect without the lock feature
        cyc(4'b1111, 4'b0010, 4'b0010, 4'b0000, "nolock0");
        cyc(4'b1111, 4'b0010, 4'b0100, 4'b0000, "nolock1");
        cyc(4'b1111, 4'b0010, 4'b1000, 4'b0000, "nolock2");
        cyc(4'b1111, 4'b0010, 4'b0001, 4'b0010, "nolock3");
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0100, "nl_drain0");
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b1000, "nl_drain1");
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0001, "nl_drain2");
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, "nl_drain3");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
